// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt request capture, masking, nesting tracking and
// priority selection for the single-cycle CPU control unit.
// Optional feature macro: IRQ_SYNC_EN. When it is defined, irq goes through a
// 2-flop synchronizer before edge detection, which adds 2 cycles of latency.
// Bit 0 has the highest priority everywhere.
module irq_ctrl #(
    parameter int unsigned         N_IRQ    = 8,
    parameter logic [N_IRQ-1:0]    MASK_RST = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] s_calli,
    input  logic [N_IRQ-1:0] s_reti,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_d,
    input  logic             ovr_clr,
    output logic [N_IRQ-1:0] min_bit_s,
    output logic [N_IRQ-1:0] min_bit_a,
    output logic [N_IRQ-1:0] mask_q,
    output logic [N_IRQ-1:0] pending_q,
    output logic [N_IRQ-1:0] overrun
);

    logic [N_IRQ-1:0] irq_src;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] in_service;
    logic [N_IRQ-1:0] ovr;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] visible;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync2;

    // Two-stage synchronizer for asynchronous request lines
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_src = sync2;
`else
    assign irq_src = irq;
`endif

    // Rising-edge detect; irq_q clears on reset so a level already high
    // at reset release is seen as one edge
    always_comb begin
        irq_edge = irq_src & ~irq_q;
    end

    // Pending, overrun, in-service and mask state; sets win over clears
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            ovr        <= '0;
            mask       <= MASK_RST;
        end else begin
            irq_q      <= irq_src;
            pending    <= (pending & ~s_calli) | irq_edge;
            ovr        <= (ovr & ~{N_IRQ{ovr_clr}}) | (irq_edge & pending & ~s_calli);
            in_service <= (in_service & ~s_reti) | s_calli;
            if (mask_we) begin
                mask <= mask_d;
            end
        end
    end

    // Lowest-set-bit isolation (x & -x) for best pending and best active
    always_comb begin
        visible   = pending & mask;
        min_bit_s = visible & (~visible + N_IRQ'(1));
        min_bit_a = in_service & (~in_service + N_IRQ'(1));
    end

    assign mask_q    = mask;
    assign pending_q = pending;
    assign overrun   = ovr;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed literal checks plus randomized stimulus compared
// every cycle against a per-bit behavioural model of irq_ctrl.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq, s_calli, s_reti, mask_d;
    logic       mask_we, ovr_clr;
    logic [7:0] min_bit_s, min_bit_a, mask_q, pending_q, overrun;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 1'b0;

    // Behavioural model state
    logic [7:0] m_prev, m_pend, m_ins, m_ovr, m_mask, m_s1, m_s2;

    irq_ctrl #(.N_IRQ(8), .MASK_RST(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .s_calli   (s_calli),
        .s_reti    (s_reti),
        .mask_we   (mask_we),
        .mask_d    (mask_d),
        .ovr_clr   (ovr_clr),
        .min_bit_s (min_bit_s),
        .min_bit_a (min_bit_a),
        .mask_q    (mask_q),
        .pending_q (pending_q),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Highest-priority (lowest-index) set bit, as one-hot; zero when none
    function automatic logic [7:0] best(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return 8'(1) << i;
        return 8'h00;
    endfunction

    // Model: apply the per-bit rules to each interrupt line independently
    always @(posedge clk) begin
        logic [7:0] src;
        if (reset) begin
            m_prev = 0; m_pend = 0; m_ins = 0; m_ovr = 0; m_s1 = 0; m_s2 = 0;
            m_mask = 8'hFF;
        end else begin
`ifdef IRQ_SYNC_EN
            src  = m_s2;
            m_s2 = m_s1;
            m_s1 = irq;
`else
            src = irq;
`endif
            for (int i = 0; i < 8; i++) begin
                bit rise;
                rise = src[i] && !m_prev[i];
                if (rise && m_pend[i] && !s_calli[i]) m_ovr[i] = 1'b1;
                else if (ovr_clr)                      m_ovr[i] = 1'b0;
                if (rise)            m_pend[i] = 1'b1;
                else if (s_calli[i]) m_pend[i] = 1'b0;
                if (s_calli[i])      m_ins[i] = 1'b1;
                else if (s_reti[i])  m_ins[i] = 1'b0;
            end
            m_prev = src;
            if (mask_we) m_mask = mask_d;
        end
        chk_en = 1'b1;
    end

    // Every-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_min_bit_s", min_bit_s, best(m_pend & m_mask));
            check("cyc_min_bit_a", min_bit_a, best(m_ins));
            check("cyc_mask_q",    mask_q,    m_mask);
            check("cyc_pending_q", pending_q, m_pend);
            check("cyc_overrun",   overrun,   m_ovr);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1; irq = 0; s_calli = 0; s_reti = 0;
        mask_we = 0; mask_d = 0; ovr_clr = 0;
        step(); step();
        reset = 0;
        check("rst_min_s", min_bit_s, 8'h00);
        check("rst_min_a", min_bit_a, 8'h00);
        check("rst_mask",  mask_q,    8'hFF);
        check("rst_pend",  pending_q, 8'h00);
        check("rst_ovr",   overrun,   8'h00);

`ifdef IRQ_SYNC_EN
        irq = 8'h02; step(); irq = 0;
        check("sync_c1", min_bit_s, 8'h00);
        step();
        check("sync_c2", min_bit_s, 8'h00);
        step();
        check("sync_c3", min_bit_s, 8'h02);
        s_calli = 8'h02; step(); s_calli = 0;
        s_reti = 8'h02; step(); s_reti = 0;
`else
        irq = 8'h08; step(); irq = 0;
        check("edge_pend", pending_q, 8'h08);
        check("edge_min_s", min_bit_s, 8'h08);
        check("edge_min_a", min_bit_a, 8'h00);
        s_calli = 8'h08; step(); s_calli = 0;
        check("call3_pend", pending_q, 8'h00);
        check("call3_min_s", min_bit_s, 8'h00);
        check("call3_min_a", min_bit_a, 8'h08);
        irq = 8'h02; step(); irq = 0;
        check("nest_min_s", min_bit_s, 8'h02);
        check("nest_min_a", min_bit_a, 8'h08);
        s_calli = 8'h02; step(); s_calli = 0;
        check("call1_min_a", min_bit_a, 8'h02);
        s_reti = 8'h02; step();
        check("reti1_min_a", min_bit_a, 8'h08);
        s_reti = 8'h08; step(); s_reti = 0;
        check("reti3_min_a", min_bit_a, 8'h00);

        mask_we = 1; mask_d = 8'hF7; step(); mask_we = 0;
        irq = 8'h08; step(); irq = 0;
        check("mask_pend", pending_q, 8'h08);
        check("mask_min_s", min_bit_s, 8'h00);
        mask_we = 1; mask_d = 8'hFF; step(); mask_we = 0;
        check("unmask_min_s", min_bit_s, 8'h08);
        s_calli = 8'h08; step(); s_calli = 0;
        s_reti = 8'h08; step(); s_reti = 0;

        irq = 8'h20; step(); irq = 0; step();
        irq = 8'h20; step(); irq = 0;
        check("ovr_set", overrun, 8'h20);
        ovr_clr = 1; step(); ovr_clr = 0;
        check("ovr_clr", overrun, 8'h00);
        check("ovr_pend", pending_q, 8'h20);

        irq = 8'h10; step(); irq = 0; step();
        irq = 8'h10; s_calli = 8'h10; step(); irq = 0; s_calli = 0;
        check("setwin_pend", pending_q, 8'h30);
        check("setwin_min_a", min_bit_a, 8'h10);
        check("setwin_ovr", overrun, 8'h00);
        s_calli = 8'h01; step(); s_calli = 0;
        check("ovfl_min_a", min_bit_a, 8'h01);
`endif

        // Level held through reset release yields exactly one pending set
        reset = 1; irq = 8'h04; step(); step(); reset = 0;
        for (int i = 0; i < 4; i++) step();
        check("hold_pend", pending_q, 8'h04);
        check("hold_ovr",  overrun,   8'h00);
        irq = 0;

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            irq = irq ^ (8'($urandom) & 8'($urandom));
            r = $urandom_range(0, 9);
            s_calli = (r < 6) ? 8'h00 : (r < 9) ? 8'(1) << $urandom_range(0, 7) : 8'($urandom);
            r = $urandom_range(0, 9);
            s_reti  = (r < 6) ? 8'h00 : (r < 9) ? 8'(1) << $urandom_range(0, 7) : 8'($urandom);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_d  = 8'($urandom);
            ovr_clr = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0; irq = 0; s_calli = 0; s_reti = 0; mask_we = 0; ovr_clr = 0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
